// File: rtl/axis_packer.sv
// axis_packer: packs RATIO narrow stream beats into one wide word with a lane keep mask
module axis_packer #(
    parameter int DATA_WIDTH = 10,
    parameter int RATIO      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic                        ready_o,
    output logic [RATIO*DATA_WIDTH-1:0] data_o,
    output logic [RATIO-1:0]            keep_o,
    output logic                        last_o,
    output logic                        valid_o,
    input  logic                        ready_i
);
    localparam int CW = $clog2(RATIO);
    localparam int WW = RATIO*DATA_WIDTH;
    logic [CW-1:0]    cnt;
    logic [WW-1:0]    coll;
    logic [WW-1:0]    word_nxt;
    logic [RATIO-1:0] keep_nxt;
    logic             in_fire;
    logic             done;
    // Lanes at and above cnt are always zero in coll, so OR-ing in the new beat is enough.
    always_comb begin
        ready_o  = !valid_o || ready_i;
        in_fire  = valid_i && ready_o;
        done     = in_fire && (last_i || cnt == CW'(RATIO-1));
        word_nxt = coll | (WW'(data_i) << (DATA_WIDTH*int'(cnt)));
        keep_nxt = {RATIO{1'b1}} >> (RATIO-1-int'(cnt));
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt     <= '0;
            coll    <= '0;
            data_o  <= '0;
            keep_o  <= '0;
            last_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            if (done) begin
                data_o <= word_nxt;
                keep_o <= keep_nxt;
                last_o <= last_i;
                cnt    <= '0;
                coll   <= '0;
            end else if (in_fire) begin
                coll <= word_nxt;
                cnt  <= cnt + 1'b1;
            end
            valid_o <= done || (valid_o && !ready_i);
        end
    end
endmodule

// File: doc/axis_packer.md
AXIS_PACKER -- requirements
Module: axis_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 10, width of one input beat in bits.
REQ-002 Parameter RATIO, default 4, input beats packed per output word; legal range 2..16.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  synchronous active-low reset, sampled on rising clk_i.
REQ-005 data_i  input  DATA_WIDTH  upstream beat payload.
REQ-006 valid_i  input  1  upstream beat valid.
REQ-007 last_i  input  1  upstream beat is final beat of a packet.
REQ-008 ready_o  output  1  packer accepts beat this cycle.
REQ-009 data_o  output  RATIO*DATA_WIDTH  packed word; lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-010 keep_o  output  RATIO  lane-valid mask for data_o.
REQ-011 last_o  output  1  packed word ends a packet.
REQ-012 valid_o  output  1  packed word valid.
REQ-013 ready_i  input  1  downstream accepts word this cycle.

Function
REQ-014 Input transfer occurs on a cycle with valid_i & ready_o; output transfer on valid_o & ready_i.
REQ-015 ready_o SHALL equal !valid_o | ready_i, with no combinational dependence on valid_i, data_i or last_i.
REQ-016 A lane counter cnt (0..RATIO-1) and a RATIO-lane collect register hold the partial word; an input transfer writes data_i into lane cnt.
REQ-017 Beat completes a word when transferred with cnt == RATIO-1 or last_i == 1.
REQ-018 On a non-completing transfer: cnt increments by 1, the lane is stored, valid_o unchanged unless REQ-021 applies.
REQ-019 On a completing transfer: next cycle data_o = collected lanes 0..cnt-1 plus data_i in lane cnt, lanes above cnt zero; keep_o bits 0..cnt set, others clear; last_o = last_i; valid_o = 1; cnt = 0; collect register cleared.
REQ-020 Lane 0 holds the first beat of a word (first-in at least significant lane).
REQ-021 When valid_o & ready_i and no completing transfer occurs that cycle, valid_o SHALL go 0 next cycle; data_o, keep_o, last_o hold their values.
REQ-022 Simultaneous output transfer and completing input transfer: new word loads, valid_o stays 1 (zero-bubble, one word per RATIO cycles sustained).
REQ-023 While valid_o & !ready_i: ready_o = 0, data_o/keep_o/last_o/valid_o held stable, cnt and collect register unchanged.
REQ-024 Latency: word appears on valid_o the cycle after its completing beat transfers.
REQ-025 last_i on a beat with cnt == 0 yields a one-lane word, keep_o = 1.
REQ-026 A packet longer than RATIO beats produces full words with last_o = 0 followed by a final word with last_o = 1.
REQ-027 Input with valid_i = 0 has no effect on state regardless of data_i/last_i.

Reset
REQ-028 rst_ni = 0 at a rising edge SHALL set valid_o = 0, data_o = 0, keep_o = 0, last_o = 0, cnt = 0, collect register = 0.
REQ-029 Reset mid-packet or with a held output word discards that data; no word is emitted for it after release.
REQ-030 ready_o = 1 in the first cycle after reset release (follows from valid_o = 0).

Verification (DATA_WIDTH=10, RATIO=4)
REQ-031 Beats 0x001,0x002,0x003,0x004 back-to-back, last on 4th, ready_i=1 -> one cycle later data_o=0x004_003_002_001 as lanes 3..0, keep_o=4'b1111, last_o=1, valid_o=1 for one cycle.
REQ-032 Beats 0x0AA,0x0BB with last on 2nd -> data_o lanes 1..0 = 0x0BB,0x0AA, lanes 3..2 = 0, keep_o=4'b0011, last_o=1.
REQ-033 12 beats continuous, last on 12th, ready_i=1 -> three words, keep_o=4'b1111 each, last_o=0,0,1, ready_o never deasserted.
REQ-034 Word pending with ready_i=0 for 5 cycles while valid_i=1 -> ready_o=0, outputs stable all 5 cycles, no beat lost; after ready_i=1, next word correct.
REQ-035 Two beats accepted then rst_ni=0 for one cycle, then 4 new beats 0x011..0x014 -> single word with only new beats, keep_o=4'b1111; all outputs 0 during reset.
REQ-036 Random valid_i/ready_i (50%) on 1000 beats with random last_i, scoreboard vs reference unpacker -> zero mismatches, no handshake-rule violation.
